fg_dac_driver: RTL and testbench
================================

Name: fg_dac_driver

Overview:
- Output stage directly downstream of the DDS oscillator; consumes its Out1 sample stream once per Enable strobe.
- Scales each sample by a 16-bit amplitude and adds a DC offset.
- Saturates the result to an offset-binary DAC code and ships it to an external SPI DAC as one serial frame per sample.
- Flags samples that arrive while a frame is still in flight.

Parameters:
- DAC_W, 12, DAC resolution in bits; legal range 8..12.
- CLK_DIV, 2, Fg_CLK cycles per SCLK half-period; legal range >=1.
- DAC_CMD, 4'h3, 4-bit command nibble placed in frame bits [15:12].

Ports:
- Fg_CLK  in  1  system clock; single clock domain.
- RESETn  in  1  asynchronous, active-low reset.
- Enable  in  1  sample strobe, same strobe that advances the oscillator.
- Sample  in  32  signed oscillator output; Q2.29, so +/-1.0 = +/-2^29.
- Amp  in  16  unsigned gain, Q0.16; 0xFFFF is approximately 1.0.
- Offset  in  16  signed DC offset in DAC LSBs.
- DacCode  out  DAC_W  last computed code, offset-binary.
- Busy  out  1  high while a sample is in the pipeline or frame.
- SampleDrop  out  1  one-cycle pulse when Enable is ignored.
- DAC_CSn  out  1  SPI chip select, active low.
- DAC_SCLK  out  1  SPI clock; idles low.
- DAC_SDI  out  1  SPI data, MSB first.
- DAC_LDACn  out  1  DAC load strobe, active low (see Optional Feature).

Behaviour:
- Reset (asynchronous, any time including mid-frame): DAC_CSn=1, DAC_SCLK=0, DAC_SDI=0, DAC_LDACn=1, Busy=0, SampleDrop=0, DacCode=2^(DAC_W-1). State returns to IDLE and any partial frame is abandoned.
- States: IDLE -> MUL -> SAT -> SHIFT -> HOLD -> IDLE.
- Cycle numbering: cycle 0 is the clock edge at which Enable=1 is sampled in IDLE.
- IDLE:
  - If Enable=1, register Sample, Amp and Offset; set Busy=1 at cycle 1; go to MUL.
  - If Enable=1 in any other state, the sample is ignored and SampleDrop pulses for exactly 1 cycle.
- MUL (cycle 1): P = signed(Sample) * signed({1'b0,Amp}), 49-bit product, registered.
- SAT (cycle 2):
  - S = P >>> (46-DAC_W), arithmetic shift with floor rounding.
  - V = S + sign-extended Offset + 2^(DAC_W-1), evaluated at 50-bit width with no intermediate overflow.
  - Clamp V to [0, 2^(DAC_W-1)*2-1]. The clamped value goes into DacCode at cycle 3 and is also loaded into the shift register.
- Frame: 16 bits = {DAC_CMD, DacCode, (12-DAC_W) zeros}.
- SHIFT:
  - DAC_CSn falls at cycle 3 with DAC_SDI = frame bit 15.
  - Each bit is held for 2*CLK_DIV cycles: DAC_SCLK low for the first CLK_DIV cycles, high for the next CLK_DIV.
  - DAC_SDI changes only on the SCLK falling transition (or at CSn fall for bit 15). The DAC samples on the rising edge.
- HOLD:
  - After the 16th high phase, DAC_SCLK returns low and DAC_CSn rises in the same cycle; DAC_SDI goes to 0.
  - DAC_CSn stays high for CLK_DIV cycles, then Busy=0 and the state returns to IDLE.
- Total busy window with CLK_DIV=2: Enable at cycle 0, CSn low during cycles 3..66, CSn high at 67, Busy low at 69. An Enable sampled at cycle 69 is accepted.
- DAC_SCLK never toggles while DAC_CSn=1.
- Amp, Offset and Sample may change freely after cycle 0 with no effect on the current frame.

Optional Feature:
- Macro: FG_DAC_LDAC_EN.
- Defined:
  - After CSn has been high for CLK_DIV cycles, DAC_LDACn is driven low for CLK_DIV cycles.
  - Busy falls in the cycle after DAC_LDACn returns high. With CLK_DIV=2, Busy falls at cycle 71.
  - Reset mid-pulse forces DAC_LDACn=1.
- Undefined: DAC_LDACn is tied to 1 and the timing is exactly as in Behaviour.

Test Plan:
- Full-scale positive: CLK_DIV=2, DAC_W=12, Sample=0x20000000, Amp=0xFFFF, Offset=0 -> DacCode=4095, SDI frame 0x3FFF. CSn low cycles 3..66; 16 SCLK rising edges, the first at cycle 5; Busy low at cycle 69.
- Full-scale negative and zero: Sample=0xE0000000 -> DacCode=0, frame 0x3000. Sample=0 -> DacCode=2048, frame 0x3800.
- Saturation: Sample=0x10000000, Amp=0xFFFF, Offset=+2000 -> S=1023, V=5071, DacCode clamps to 4095. Offset=-3500 -> DacCode clamps to 0.
- Back-pressure: Enable pulses at cycles 0, 10 and 69 -> SampleDrop high only at cycle 10. The frame from the cycle-69 sample starts with CSn falling at cycle 72.
- Reset mid-frame: assert RESETn=0 at cycle 30 -> outputs asynchronously return to CSn=1, SCLK=0, Busy=0, DacCode=2048. The first Enable after release produces a complete, correct frame.
- FG_DAC_LDAC_EN defined: single sample with CLK_DIV=2 -> LDACn low during cycles 69..70, Busy low at cycle 71. Without the macro, LDACn stays 1 throughout.

Source files
------------

// File: rtl/fg_dac_driver.sv
// Scales DDS samples by Amp, adds Offset, saturates and ships one SPI DAC frame per sample.
// Define FG_DAC_LDAC_EN to pulse DAC_LDACn after each frame.
module fg_dac_driver #(
  parameter int          DAC_W   = 12,
  parameter int          CLK_DIV = 2,
  parameter logic [3:0]  DAC_CMD = 4'h3
) (
  input  logic              Fg_CLK,
  input  logic              RESETn,
  input  logic              Enable,
  input  logic [31:0]       Sample,
  input  logic [15:0]       Amp,
  input  logic [15:0]       Offset,
  output logic [DAC_W-1:0]  DacCode,
  output logic              Busy,
  output logic              SampleDrop,
  output logic              DAC_CSn,
  output logic              DAC_SCLK,
  output logic              DAC_SDI,
  output logic              DAC_LDACn
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MUL   = 3'd1;
  localparam logic [2:0] S_SAT   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam int SH = 46 - DAC_W;
  localparam int CW = $clog2(2 * CLK_DIV + 1);
`ifdef FG_DAC_LDAC_EN
  localparam int END_K = 2 * CLK_DIV - 1;
`else
  localparam int END_K = CLK_DIV - 1;
`endif

  localparam logic signed [49:0] HALF = 50'(2 ** (DAC_W - 1));
  localparam logic signed [49:0] VMAX = 50'(2 ** DAC_W - 1);

  logic [2:0]         state;
  logic               sat_ph;
  logic signed [31:0] smp_q;
  logic [15:0]        amp_q;
  logic signed [15:0] off_q;
  logic signed [48:0] prod_q;
  logic signed [49:0] v_q;
  logic [CW-1:0]      cnt;
  logic [3:0]         bitc;
  logic [15:0]        sh;

  logic signed [16:0] amp_s;
  logic signed [49:0] v_d;
  logic [DAC_W-1:0]   clamp;
  logic [15:0]        frame;
  logic [CW-1:0]      cnt_n;

  always_comb begin
    amp_s = $signed({1'b0, amp_q});
    v_d   = 50'(prod_q >>> SH) + 50'(off_q) + HALF;
    if (v_q < 0)
      clamp = '0;
    else if (v_q > VMAX)
      clamp = '1;
    else
      clamp = v_q[DAC_W-1:0];
    frame = {DAC_CMD, 12'(clamp) << (12 - DAC_W)};
    cnt_n = cnt + CW'(1);
  end

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state      <= S_IDLE;
      sat_ph     <= 1'b0;
      smp_q      <= '0;
      amp_q      <= '0;
      off_q      <= '0;
      prod_q     <= '0;
      v_q        <= '0;
      cnt        <= '0;
      bitc       <= '0;
      sh         <= '0;
      DacCode    <= DAC_W'(2 ** (DAC_W - 1));
      Busy       <= 1'b0;
      SampleDrop <= 1'b0;
      DAC_CSn    <= 1'b1;
      DAC_SCLK   <= 1'b0;
      DAC_SDI    <= 1'b0;
    end else begin
      SampleDrop <= Enable && (state != S_IDLE);
      Busy       <= state != S_IDLE;
      unique case (state)
        S_IDLE: begin
          if (Enable) begin
            smp_q <= Sample;
            amp_q <= Amp;
            off_q <= Offset;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          prod_q <= 49'(smp_q) * 49'(amp_s);
          state  <= S_SAT;
        end
        // first pass forms the sum, second clamps and opens the frame
        S_SAT: begin
          if (!sat_ph) begin
            v_q    <= v_d;
            sat_ph <= 1'b1;
          end else begin
            sat_ph   <= 1'b0;
            DacCode  <= clamp;
            sh       <= {frame[14:0], 1'b0};
            DAC_SDI  <= frame[15];
            DAC_CSn  <= 1'b0;
            DAC_SCLK <= 1'b0;
            cnt      <= '0;
            bitc     <= '0;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cnt == CW'(CLK_DIV - 1)) begin
            cnt <= '0;
            if (!DAC_SCLK) begin
              DAC_SCLK <= 1'b1;
            end else if (bitc == 4'd15) begin
              DAC_SCLK <= 1'b0;
              DAC_CSn  <= 1'b1;
              DAC_SDI  <= 1'b0;
              state    <= (END_K == 0) ? S_IDLE : S_HOLD;
            end else begin
              DAC_SCLK <= 1'b0;
              DAC_SDI  <= sh[15];
              sh       <= {sh[14:0], 1'b0};
              bitc     <= bitc + 4'd1;
            end
          end else begin
            cnt <= cnt_n;
          end
        end
        S_HOLD: begin
          cnt <= cnt_n;
          if (cnt_n == CW'(END_K))
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FG_DAC_LDAC_EN
  // load strobe occupies the second CLK_DIV window after CSn rises
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn)
      DAC_LDACn <= 1'b1;
    else
      DAC_LDACn <= !((state == S_HOLD) && (cnt_n >= CW'(CLK_DIV)));
  end
`else
  assign DAC_LDACn = 1'b1;
`endif

endmodule

// File: tb/tb_fg_dac_driver.sv
// Directed bench for fg_dac_driver (DAC_W=12, CLK_DIV=2).
// Cycle k below is the value seen on the falling edge after active edge k.
module tb_fg_dac_driver;

  logic        Fg_CLK = 1'b0;
  logic        RESETn;
  logic        Enable;
  logic [31:0] Sample;
  logic [15:0] Amp;
  logic [15:0] Offset;
  logic [11:0] DacCode;
  logic        Busy;
  logic        SampleDrop;
  logic        DAC_CSn;
  logic        DAC_SCLK;
  logic        DAC_SDI;
  logic        DAC_LDACn;

  int vecs = 0;
  int miss = 0;

`ifdef FG_DAC_LDAC_EN
  localparam int BUSY_END = 71;
  localparam int LD_N     = 2;
  localparam int LD_FIRST = 69;
`else
  localparam int BUSY_END = 69;
  localparam int LD_N     = 0;
  localparam int LD_FIRST = -1;
`endif

  fg_dac_driver #(.DAC_W(12), .CLK_DIV(2), .DAC_CMD(4'h3)) dut (
    .Fg_CLK     (Fg_CLK),
    .RESETn     (RESETn),
    .Enable     (Enable),
    .Sample     (Sample),
    .Amp        (Amp),
    .Offset     (Offset),
    .DacCode    (DacCode),
    .Busy       (Busy),
    .SampleDrop (SampleDrop),
    .DAC_CSn    (DAC_CSn),
    .DAC_SCLK   (DAC_SCLK),
    .DAC_SDI    (DAC_SDI),
    .DAC_LDACn  (DAC_LDACn)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic [31:0] s, input logic [15:0] a,
                           input logic [15:0] o, input logic [11:0] code,
                           input string tag);
    logic [15:0] fr;
    logic [11:0] dc3;
    logic        psclk;
    int cs_fall, cs_rise, rise1, rises, bhi, blo, ldlo, ldn, bad;
    fr = '0; dc3 = '0;
    cs_fall = -1; cs_rise = -1; rise1 = -1; rises = 0;
    bhi = -1; blo = -1; ldlo = -1; ldn = 0; bad = 0;
    @(negedge Fg_CLK);
    Sample = s; Amp = a; Offset = o; Enable = 1'b1;
    @(negedge Fg_CLK);
    Enable = 1'b0;
    Sample = $urandom; Amp = 16'($urandom); Offset = 16'($urandom);
    psclk = DAC_SCLK;
    for (int k = 0; k < 80; k++) begin
      if (k > 0) @(negedge Fg_CLK);
      if (cs_fall < 0 && !DAC_CSn) cs_fall = k;
      if (cs_fall >= 0 && cs_rise < 0 && DAC_CSn) cs_rise = k;
      if (DAC_SCLK && !psclk) begin
        rises++;
        if (rise1 < 0) rise1 = k;
        fr = {fr[14:0], DAC_SDI};
      end
      if (DAC_SCLK && DAC_CSn) bad++;
      if (bhi < 0 && Busy) bhi = k;
      if (bhi >= 0 && blo < 0 && !Busy) blo = k;
      if (!DAC_LDACn) begin
        ldn++;
        if (ldlo < 0) ldlo = k;
      end
      if (k == 3) dc3 = DacCode;
      psclk = DAC_SCLK;
    end
    chk({tag, " code"}, 32'(dc3), 32'(code));
    chk({tag, " frame"}, 32'(fr), 32'({4'h3, code}));
    chk({tag, " cs_fall"}, cs_fall, 3);
    chk({tag, " cs_rise"}, cs_rise, 67);
    chk({tag, " sclk_first"}, rise1, 5);
    chk({tag, " sclk_n"}, rises, 16);
    chk({tag, " sclk_cs_hi"}, bad, 0);
    chk({tag, " busy_hi"}, bhi, 1);
    chk({tag, " busy_lo"}, blo, BUSY_END);
    chk({tag, " ldac_n"}, ldn, LD_N);
    chk({tag, " ldac_first"}, ldlo, LD_FIRST);
  endtask

  initial begin
    int drops, dropk;
    logic cs_a, cs_b, b_end;
    logic [11:0] dc_a, dc_b;
    RESETn = 1'b0; Enable = 1'b0;
    Sample = '0; Amp = '0; Offset = '0;
    repeat (2) @(negedge Fg_CLK);
    chk("rst csn", 32'(DAC_CSn), 1);
    chk("rst sclk", 32'(DAC_SCLK), 0);
    chk("rst sdi", 32'(DAC_SDI), 0);
    chk("rst ldac", 32'(DAC_LDACn), 1);
    chk("rst busy", 32'(Busy), 0);
    chk("rst drop", 32'(SampleDrop), 0);
    chk("rst code", 32'(DacCode), 2048);
    RESETn = 1'b1;
    @(negedge Fg_CLK);

    run_frame(32'h2000_0000, 16'hFFFF, 16'h0000, 12'd4095, "fs_pos");
    run_frame(32'hE000_0000, 16'hFFFF, 16'h0000, 12'd0, "fs_neg");
    run_frame(32'h0000_0000, 16'hFFFF, 16'h0000, 12'd2048, "zero");
    run_frame(32'h2000_0000, 16'h8000, 16'h0000, 12'd3072, "half_amp");
    run_frame(32'h1000_0000, 16'hFFFF, 16'd2000, 12'd4095, "sat_hi");
    run_frame(32'h1000_0000, 16'hFFFF, 16'hF254, 12'd0, "sat_lo");
    run_frame(32'h1000_0000, 16'hFFFF, 16'hFF9C, 12'd2971, "neg_off");

    // back-pressure: strobes at cycles 0, 10 and BUSY_END
    drops = 0; dropk = -1;
    cs_a = 1'b0; cs_b = 1'b1; b_end = 1'b1; dc_a = '0; dc_b = '0;
    @(negedge Fg_CLK);
    Sample = 32'h2000_0000; Amp = 16'hFFFF; Offset = '0; Enable = 1'b1;
    for (int k = 0; k <= BUSY_END + 4; k++) begin
      @(negedge Fg_CLK);
      if (SampleDrop) begin
        drops++;
        if (dropk < 0) dropk = k;
      end
      if (k == 20) dc_a = DacCode;
      if (k == BUSY_END) b_end = Busy;
      if (k == BUSY_END + 2) cs_a = DAC_CSn;
      if (k == BUSY_END + 3) begin
        cs_b = DAC_CSn;
        dc_b = DacCode;
      end
      Enable = (k == 9) || (k == BUSY_END - 1);
      if (k == 9) Sample = 32'hE000_0000;
      if (k == BUSY_END - 1) Sample = 32'h0;
    end
    chk("bp drop_n", drops, 1);
    chk("bp drop_at", dropk, 10);
    chk("bp code_kept", 32'(dc_a), 4095);
    chk("bp busy_end", 32'(b_end), 0);
    chk("bp cs_pre", 32'(cs_a), 1);
    chk("bp cs_fall", 32'(cs_b), 0);
    chk("bp code2", 32'(dc_b), 2048);
    repeat (80) @(negedge Fg_CLK);

    // asynchronous reset in the middle of a frame
    Sample = 32'hE000_0000; Amp = 16'hFFFF; Offset = '0; Enable = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge Fg_CLK);
      Enable = 1'b0;
    end
    chk("mid csn_lo", 32'(DAC_CSn), 0);
    chk("mid code0", 32'(DacCode), 0);
    RESETn = 1'b0;
    #1;
    chk("mid rst csn", 32'(DAC_CSn), 1);
    chk("mid rst sclk", 32'(DAC_SCLK), 0);
    chk("mid rst sdi", 32'(DAC_SDI), 0);
    chk("mid rst busy", 32'(Busy), 0);
    chk("mid rst ldac", 32'(DAC_LDACn), 1);
    chk("mid rst code", 32'(DacCode), 2048);
    @(negedge Fg_CLK);
    RESETn = 1'b1;
    run_frame(32'h1000_0000, 16'hFFFF, 16'h0000, 12'd3071, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
